// File: rtl/intersection_phase_scheduler_pkg.sv
// rtl/intersection_phase_scheduler_pkg.sv - shared phase codes, lamp encodings and direction codes
package intersection_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } phase_t;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // Green phase owned by a given road direction.
    function automatic phase_t green_of(input logic dir);
        return (dir == DIR_EW) ? EW_GREEN : NS_GREEN;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_timer.sv
// rtl/intersection_phase_scheduler_timer.sv - phase timer with sync clear and saturating increment
module intersection_phase_scheduler_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    output logic [TIMER_W-1:0] count
);

    logic [TIMER_W-1:0] count_d;
    logic [TIMER_W-1:0] count_q;

    // Clear wins over counting; the count parks at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - two-road intersection phase sequencer with actuation, walk and pre-emption
module intersection_phase_scheduler
    import intersection_phase_scheduler_pkg::*;
#(
    parameter int TIMER_W   = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_ns,
    input  logic       det_ew,
    input  logic       high_ns,
    input  logic       high_ew,
    input  logic       ped_req,
    input  logic       emg,
    input  logic       emg_dir,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    // Timer value seen on the last cycle of each timed state.
    localparam logic [TIMER_W-1:0] GMIN_LAST   = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMAX_LAST   = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(WALK_T - 1);

    phase_t             state_d, state_q;
    logic               next_dir_d, next_dir_q;
    logic               ped_pending_d, ped_pending_q;
    logic [TIMER_W-1:0] timer;
    logic               timer_clear;
    logic               ns_cross, ew_cross;
    logic [TIMER_W-1:0] ns_last, ew_last;

    assign ns_cross = det_ew | ped_pending_q;
    assign ew_cross = det_ns | ped_pending_q;
    assign ns_last  = high_ns ? GMAX_LAST : GMIN_LAST;
    assign ew_last  = high_ew ? GMAX_LAST : GMIN_LAST;

    // Timer restarts from zero whenever the state changes.
    assign timer_clear = (state_d != state_q);

    intersection_phase_scheduler_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .count (timer)
    );

    // Next-state logic: emergency pre-emption first, then actuated timing.
    // Greens compare with >= so a late demand or a dropped high flag exits at once.
    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            ALL_RED: begin
                if (timer == ALLRED_LAST) begin
                    if (emg) begin
                        state_d = green_of(emg_dir);
                    end else if (ped_pending_q) begin
                        state_d = PED_WALK;
                    end else begin
                        state_d = green_of(next_dir_q);
                    end
                end
            end
            NS_GREEN: begin
                if (emg) begin
                    if (emg_dir == DIR_EW) begin
                        state_d = NS_YELLOW;
                    end
                end else if (ns_cross && (timer >= ns_last)) begin
                    state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    state_d    = ALL_RED;
                    next_dir_d = DIR_EW;
                end
            end
            EW_GREEN: begin
                if (emg) begin
                    if (emg_dir == DIR_NS) begin
                        state_d = EW_YELLOW;
                    end
                end else if (ew_cross && (timer >= ew_last)) begin
                    state_d = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    state_d    = ALL_RED;
                    next_dir_d = DIR_NS;
                end
            end
            PED_WALK: begin
                if (emg) begin
                    state_d = ALL_RED;
                end else if (timer == WALK_LAST) begin
                    state_d = green_of(next_dir_q);
                end
            end
            default: begin
                state_d = ALL_RED;
            end
        endcase
    end

    // Pedestrian latch: a walk consumes the request, and presses during a walk are ignored.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if ((state_d == PED_WALK) || (state_q == PED_WALK)) begin
            ped_pending_d = 1'b0;
        end else if (ped_req) begin
            ped_pending_d = 1'b1;
        end
    end

    // State registers; reset forces all-red immediately, skipping any yellow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ALL_RED;
            next_dir_q    <= DIR_NS;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Moore lamp decode from the registered state.
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
        case (state_q)
            NS_GREEN:  ns_light = LIGHT_GRN;
            NS_YELLOW: ns_light = LIGHT_YEL;
            EW_GREEN:  ew_light = LIGHT_GRN;
            EW_YELLOW: ew_light = LIGHT_YEL;
            PED_WALK:  walk     = 1'b1;
            default:   ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - directed and random checks of the intersection phase scheduler
module tb_intersection_phase_scheduler;
    import intersection_phase_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk;

    int checks = 0;
    int errors = 0;

    // Input word for a run of cycles: {assert_reset, det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir}
    localparam logic [7:0] I_NONE = 8'b0000_0000;
    localparam logic [7:0] I_RST  = 8'b1000_0000;
    localparam logic [7:0] I_DNS  = 8'b0100_0000;
    localparam logic [7:0] I_DEW  = 8'b0010_0000;
    localparam logic [7:0] I_HNS  = 8'b0001_0000;
    localparam logic [7:0] I_PED  = 8'b0000_0100;
    localparam logic [7:0] I_EMG  = 8'b0000_0010;
    localparam logic [7:0] I_EDIR = 8'b0000_0001;

    typedef struct {
        phase_t     st;
        int         n;
        logic [7:0] in;
    } step_t;

    intersection_phase_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .det_ns   (det_ns),
        .det_ew   (det_ew),
        .high_ns  (high_ns),
        .high_ew  (high_ew),
        .ped_req  (ped_req),
        .emg      (emg),
        .emg_dir  (emg_dir),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // Expected {ns_light, ew_light, walk} for each phase.
    function automatic logic [6:0] lamps(input phase_t p);
        case (p)
            ALL_RED:   return {3'b100, 3'b100, 1'b0};
            NS_GREEN:  return {3'b001, 3'b100, 1'b0};
            NS_YELLOW: return {3'b010, 3'b100, 1'b0};
            EW_GREEN:  return {3'b100, 3'b001, 1'b0};
            EW_YELLOW: return {3'b100, 3'b010, 1'b0};
            PED_WALK:  return {3'b100, 3'b100, 1'b1};
            default:   return 7'b0;
        endcase
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = 7'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ns_light !== 3'b100) begin errors++; $display("FAIL reset_ns: ns_light=%b expected 100", ns_light); end
        checks++;
        if (ew_light !== 3'b100) begin errors++; $display("FAIL reset_ew: ew_light=%b expected 100", ew_light); end
        checks++;
        if (walk !== 1'b0) begin errors++; $display("FAIL reset_walk: walk=%b expected 0", walk); end
        checks++;
        if (phase !== ALL_RED) begin errors++; $display("FAIL reset_phase: phase=%0d expected %0d", phase, ALL_RED); end
    endtask

    task automatic test_low_traffic();
        step_t tbl [5];
        tbl = '{'{ALL_RED, 1, I_DEW}, '{NS_GREEN, 4, I_DEW}, '{NS_YELLOW, 2, I_DEW},
                '{ALL_RED, 1, I_DEW}, '{EW_GREEN, 15, I_DEW}};
        apply_reset();
        for (int k = 0; k < $size(tbl); k++) begin
            reset = ~tbl[k].in[7];
            {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = tbl[k].in[6:0];
            for (int j = 0; j < tbl[k].n; j++) begin
                checks++;
                if (phase !== tbl[k].st) begin errors++; $display("FAIL low_traffic step %0d cycle %0d: phase=%0d expected %0d", k, j, phase, tbl[k].st); end
                checks++;
                if ({ns_light, ew_light, walk} !== lamps(tbl[k].st)) begin errors++; $display("FAIL low_traffic_lamps step %0d cycle %0d: lamps=%b expected %b", k, j, {ns_light, ew_light, walk}, lamps(tbl[k].st)); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_high_ns();
        step_t tbl [5];
        tbl = '{'{ALL_RED, 1, I_DEW | I_HNS}, '{NS_GREEN, 10, I_DEW | I_HNS}, '{NS_YELLOW, 2, I_DEW | I_HNS},
                '{ALL_RED, 1, I_DEW | I_HNS}, '{EW_GREEN, 3, I_DEW | I_HNS}};
        apply_reset();
        for (int k = 0; k < $size(tbl); k++) begin
            reset = ~tbl[k].in[7];
            {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = tbl[k].in[6:0];
            for (int j = 0; j < tbl[k].n; j++) begin
                checks++;
                if (phase !== tbl[k].st) begin errors++; $display("FAIL high_ns step %0d cycle %0d: phase=%0d expected %0d", k, j, phase, tbl[k].st); end
                checks++;
                if ({ns_light, ew_light, walk} !== lamps(tbl[k].st)) begin errors++; $display("FAIL high_ns_lamps step %0d cycle %0d: lamps=%b expected %b", k, j, {ns_light, ew_light, walk}, lamps(tbl[k].st)); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_high_drop();
        step_t tbl [6];
        tbl = '{'{ALL_RED, 1, I_DEW | I_HNS}, '{NS_GREEN, 6, I_DEW | I_HNS}, '{NS_GREEN, 1, I_DEW},
                '{NS_YELLOW, 2, I_DEW}, '{ALL_RED, 1, I_DEW}, '{EW_GREEN, 3, I_DEW}};
        apply_reset();
        for (int k = 0; k < $size(tbl); k++) begin
            reset = ~tbl[k].in[7];
            {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = tbl[k].in[6:0];
            for (int j = 0; j < tbl[k].n; j++) begin
                checks++;
                if (phase !== tbl[k].st) begin errors++; $display("FAIL high_drop step %0d cycle %0d: phase=%0d expected %0d", k, j, phase, tbl[k].st); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_pedestrian();
        step_t tbl [9];
        tbl = '{'{ALL_RED, 1, I_NONE}, '{NS_GREEN, 1, I_PED}, '{NS_GREEN, 3, I_NONE},
                '{NS_YELLOW, 2, I_NONE}, '{ALL_RED, 1, I_NONE}, '{PED_WALK, 2, I_NONE},
                '{PED_WALK, 1, I_PED}, '{PED_WALK, 3, I_NONE}, '{EW_GREEN, 12, I_NONE}};
        apply_reset();
        for (int k = 0; k < $size(tbl); k++) begin
            reset = ~tbl[k].in[7];
            {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = tbl[k].in[6:0];
            for (int j = 0; j < tbl[k].n; j++) begin
                checks++;
                if (phase !== tbl[k].st) begin errors++; $display("FAIL pedestrian step %0d cycle %0d: phase=%0d expected %0d", k, j, phase, tbl[k].st); end
                checks++;
                if ({ns_light, ew_light, walk} !== lamps(tbl[k].st)) begin errors++; $display("FAIL pedestrian_lamps step %0d cycle %0d: lamps=%b expected %b", k, j, {ns_light, ew_light, walk}, lamps(tbl[k].st)); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_emergency();
        step_t tbl [10];
        tbl = '{'{ALL_RED, 1, I_NONE}, '{NS_GREEN, 1, I_NONE}, '{NS_GREEN, 1, I_EMG | I_EDIR},
                '{NS_YELLOW, 2, I_EMG | I_EDIR}, '{ALL_RED, 1, I_EMG | I_EDIR},
                '{EW_GREEN, 15, I_EMG | I_EDIR | I_DNS}, '{EW_GREEN, 1, I_DNS},
                '{EW_YELLOW, 2, I_DNS}, '{ALL_RED, 1, I_DNS}, '{NS_GREEN, 2, I_DNS}};
        apply_reset();
        for (int k = 0; k < $size(tbl); k++) begin
            reset = ~tbl[k].in[7];
            {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = tbl[k].in[6:0];
            for (int j = 0; j < tbl[k].n; j++) begin
                checks++;
                if (phase !== tbl[k].st) begin errors++; $display("FAIL emergency step %0d cycle %0d: phase=%0d expected %0d", k, j, phase, tbl[k].st); end
                checks++;
                if ({ns_light, ew_light, walk} !== lamps(tbl[k].st)) begin errors++; $display("FAIL emergency_lamps step %0d cycle %0d: lamps=%b expected %b", k, j, {ns_light, ew_light, walk}, lamps(tbl[k].st)); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_emg_walk();
        step_t tbl [12];
        tbl = '{'{ALL_RED, 1, I_PED}, '{NS_GREEN, 4, I_NONE}, '{NS_YELLOW, 2, I_NONE},
                '{ALL_RED, 1, I_NONE}, '{PED_WALK, 3, I_NONE}, '{PED_WALK, 1, I_EMG | I_DEW},
                '{ALL_RED, 1, I_EMG | I_DEW}, '{NS_GREEN, 5, I_EMG | I_DEW}, '{NS_GREEN, 1, I_DEW},
                '{NS_YELLOW, 2, I_DEW}, '{ALL_RED, 1, I_DEW}, '{EW_GREEN, 2, I_DEW}};
        apply_reset();
        for (int k = 0; k < $size(tbl); k++) begin
            reset = ~tbl[k].in[7];
            {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = tbl[k].in[6:0];
            for (int j = 0; j < tbl[k].n; j++) begin
                checks++;
                if (phase !== tbl[k].st) begin errors++; $display("FAIL emg_walk step %0d cycle %0d: phase=%0d expected %0d", k, j, phase, tbl[k].st); end
                checks++;
                if ({ns_light, ew_light, walk} !== lamps(tbl[k].st)) begin errors++; $display("FAIL emg_walk_lamps step %0d cycle %0d: lamps=%b expected %b", k, j, {ns_light, ew_light, walk}, lamps(tbl[k].st)); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t tbl [6];
        tbl = '{'{ALL_RED, 1, I_DEW}, '{NS_GREEN, 2, I_DEW}, '{NS_GREEN, 1, I_DEW | I_RST},
                '{ALL_RED, 1, I_DEW | I_RST}, '{ALL_RED, 1, I_DEW}, '{NS_GREEN, 2, I_DEW}};
        apply_reset();
        for (int k = 0; k < $size(tbl); k++) begin
            reset = ~tbl[k].in[7];
            {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = tbl[k].in[6:0];
            for (int j = 0; j < tbl[k].n; j++) begin
                checks++;
                if (phase !== tbl[k].st) begin errors++; $display("FAIL reset_mid step %0d cycle %0d: phase=%0d expected %0d", k, j, phase, tbl[k].st); end
                checks++;
                if ({ns_light, ew_light, walk} !== lamps(tbl[k].st)) begin errors++; $display("FAIL reset_mid_lamps step %0d cycle %0d: lamps=%b expected %b", k, j, {ns_light, ew_light, walk}, lamps(tbl[k].st)); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random_safety();
        int ns_run = 0;
        int ew_run = 0;
        apply_reset();
        reset = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            det_ns  = 1'($urandom_range(0, 1));
            det_ew  = 1'($urandom_range(0, 1));
            high_ns = ($urandom_range(0, 3) == 0);
            high_ew = ($urandom_range(0, 3) == 0);
            ped_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) emg = ~emg;
            if ($urandom_range(0, 31) == 0) emg_dir = ~emg_dir;
            @(negedge clk);
            checks++;
            if ({$onehot(ns_light), $onehot(ew_light)} !== 2'b11) begin
                errors++; $display("FAIL random_onehot cycle %0d: ns=%b ew=%b expected one-hot", c, ns_light, ew_light);
            end
            checks++;
            if ((ns_light !== 3'b100) && (ew_light !== 3'b100)) begin
                errors++; $display("FAIL random_conflict cycle %0d: ns=%b ew=%b expected one road red", c, ns_light, ew_light);
            end
            checks++;
            if (walk && ({ns_light, ew_light} !== 6'b100100)) begin
                errors++; $display("FAIL random_walk cycle %0d: walk=1 ns=%b ew=%b expected both 100", c, ns_light, ew_light);
            end
            if (ns_light === 3'b010) ns_run++;
            else if (ns_run != 0) begin
                checks++;
                if (ns_run !== 2) begin errors++; $display("FAIL random_ns_yellow cycle %0d: length=%0d expected 2", c, ns_run); end
                ns_run = 0;
            end
            if (ew_light === 3'b010) ew_run++;
            else if (ew_run != 0) begin
                checks++;
                if (ew_run !== 2) begin errors++; $display("FAIL random_ew_yellow cycle %0d: length=%0d expected 2", c, ew_run); end
                ew_run = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        {det_ns, det_ew, high_ns, high_ew, ped_req, emg, emg_dir} = 7'b0;
        @(negedge clk);
        test_reset();
        test_low_traffic();
        test_high_ns();
        test_high_drop();
        test_pedestrian();
        test_emergency();
        test_emg_walk();
        test_reset_mid();
        test_random_safety();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
